pwm_carrier_counter: RTL

Parametrised successor to the fixed 5-bit free-running counter. Generates the PWM carrier for the 3-phase motor modulator with three count modes: up-sawtooth, down-sawtooth and up/down triangle (centre-aligned). The period is programmable and shadowed, so updates land only on a period boundary. The block also supports synchronous load, count enable, and registered zero and top event pulses that the comparator stage consumes.

---
 rtl/pwm_carrier_counter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_carrier_counter.sv
// PWM carrier counter: up-wrap, down-reload and up/down triangle modes, shadowed period, event pulses.
// Optional prescaler compiled in with PWM_CARRIER_PRESCALE_EN.
module pwm_carrier_counter #(
    parameter int WIDTH = 5,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] period,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] presc,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             zero_p,
    output logic             top_p,
    output logic [WIDTH-1:0] period_q
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    logic             tick;
    logic [WIDTH-1:0] cnt_nx;
    logic             dir_nx;
    logic             zero_nx;
    logic             top_nx;
    logic [WIDTH-1:0] period_nx;

`ifdef PWM_CARRIER_PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == presc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (load || !en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end
`else
    logic unused_presc;

    assign tick         = en;
    assign unused_presc = ^presc;
`endif

    always_comb begin
        cnt_nx    = cnt;
        dir_nx    = dir;
        zero_nx   = 1'b0;
        top_nx    = 1'b0;
        period_nx = period_q;

        if (load) begin
            cnt_nx = load_val;
        end else if (tick && (mode != MODE_HOLD)) begin
            if (period_q == ZERO) begin
                // degenerate carrier: both events every tick, shadow still refreshes
                cnt_nx    = ZERO;
                dir_nx    = (mode == MODE_DOWN);
                zero_nx   = 1'b1;
                top_nx    = 1'b1;
                period_nx = period;
            end else begin
                case (mode)
                    MODE_UP: begin
                        dir_nx = 1'b0;
                        if (cnt >= period_q) begin
                            cnt_nx    = ZERO;
                            zero_nx   = 1'b1;
                            period_nx = period;
                        end else begin
                            cnt_nx = cnt + ONE;
                            top_nx = ((cnt + ONE) == period_q);
                        end
                    end
                    MODE_DOWN: begin
                        dir_nx = 1'b1;
                        if (cnt == ZERO) begin
                            cnt_nx    = period;
                            period_nx = period;
                            top_nx    = 1'b1;
                        end else begin
                            cnt_nx  = cnt - ONE;
                            zero_nx = (cnt == ONE);
                        end
                    end
                    default: begin
                        if (!dir) begin
                            if (cnt >= period_q) begin
                                dir_nx  = 1'b1;
                                cnt_nx  = period_q - ONE;
                                zero_nx = (period_q == ONE);
                            end else begin
                                cnt_nx = cnt + ONE;
                                top_nx = ((cnt + ONE) == period_q);
                            end
                        end else if (cnt == ZERO) begin
                            // valley: turn around and take the new period
                            dir_nx    = 1'b0;
                            cnt_nx    = ONE;
                            period_nx = period;
                            top_nx    = (period == ONE);
                        end else begin
                            cnt_nx  = cnt - ONE;
                            zero_nx = (cnt == ONE);
                        end
                    end
                endcase
            end
        end else if (!en && (mode != MODE_HOLD)) begin
            period_nx = period;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dir      <= 1'b0;
            zero_p   <= 1'b0;
            top_p    <= 1'b0;
            period_q <= '1;
        end else begin
            cnt      <= cnt_nx;
            dir      <= dir_nx;
            zero_p   <= zero_nx;
            top_p    <= top_nx;
            period_q <= period_nx;
        end
    end

endmodule
